// File: rtl/proc_io_fl_pkg.sv
// proc_io_fl_pkg: shared sizing helpers and reset word for the processor I/O subsystem
package proc_io_fl_pkg;
  localparam int RST_WORD = 0;
  function automatic int nbw(int nbmant, int nbexpo);
    return nbmant + nbexpo + 1;
  endfunction
  function automatic int ptrw(int fdepth);
    return $clog2(fdepth) + 1;
  endfunction
endpackage

// File: rtl/fifo_fl.sv
// fifo_fl: single-clock first-word-fall-through FIFO, extra pointer MSB distinguishes full from empty
module fifo_fl import proc_io_fl_pkg::*; #(
  parameter int NBDATA = 23,
  parameter int FDEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [NBDATA-1:0] din,
  input  logic              pop,
  output logic [NBDATA-1:0] dout,
  output logic              full,
  output logic              empty
);
  localparam int PW = ptrw(FDEPTH);
  logic [PW-1:0] wp, rp;
  logic [NBDATA-1:0] mem [FDEPTH];
  logic do_push, do_pop;
  assign full = (wp[PW-1] != rp[PW-1]) && (wp[PW-2:0] == rp[PW-2:0]);
  assign empty = wp == rp;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rp[PW-2:0]];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
    end
  always_ff @(posedge clk)
    if (do_push) mem[wp[PW-2:0]] <= din;
endmodule

// File: rtl/proc_io_fl.sv
// proc_io_fl: buffered input FIFOs and handshaked output registers for the proc_fl family.
// Define IO_STATUS_EN to build the sticky underflow/overflow flags.
module proc_io_fl import proc_io_fl_pkg::*; #(
  parameter int NBMANT = 16,
  parameter int NBEXPO = 6,
  parameter int NUIOIN = 8,
  parameter int NUIOOU = 8,
  parameter int FDEPTH = 4,
  localparam int NBW = nbw(NBMANT, NBEXPO),
  localparam int AIW = NUIOIN > 1 ? $clog2(NUIOIN) : 1,
  localparam int AOW = NUIOOU > 1 ? $clog2(NUIOOU) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [AIW-1:0]        addr_in,
  input  logic                  req_in,
  output logic [NBW-1:0]        io_in,
  input  logic [AOW-1:0]        addr_out,
  input  logic                  out_en,
  input  logic [NBW-1:0]        io_out,
  input  logic [NUIOIN*NBW-1:0] in_data,
  input  logic [NUIOIN-1:0]     in_valid,
  output logic [NUIOIN-1:0]     in_ready,
  output logic [NUIOOU*NBW-1:0] out_data,
  output logic [NUIOOU-1:0]     out_valid,
  input  logic [NUIOOU-1:0]     out_ready,
  output logic [NUIOIN-1:0]     in_udf,
  output logic [NUIOOU-1:0]     ou_ovf,
  input  logic                  stat_clr
);
  logic [NBW-1:0] head [NUIOIN];
  logic [NBW-1:0] hold [NUIOIN];
  logic [NUIOIN-1:0] full, empty, push, pop, udf_ev;
  logic [NUIOOU-1:0] wr, ovf_ev;
  logic in_sel;
  assign in_sel = 32'(addr_in) < NUIOIN;
  assign in_ready = ~full;
  for (genvar k = 0; k < NUIOIN; k++) begin : g_in
    assign push[k] = in_valid[k] && !full[k];
    assign pop[k] = req_in && 32'(addr_in) == k && !empty[k];
    assign udf_ev[k] = req_in && 32'(addr_in) == k && empty[k];
    fifo_fl #(.NBDATA(NBW), .FDEPTH(FDEPTH)) u_fifo (
      .clk(clk), .rst(rst), .push(push[k]), .din(in_data[k*NBW +: NBW]),
      .pop(pop[k]), .dout(head[k]), .full(full[k]), .empty(empty[k])
    );
  end
  for (genvar j = 0; j < NUIOOU; j++) begin : g_ou
    assign wr[j] = out_en && 32'(addr_out) == j;
    assign ovf_ev[j] = wr[j] && out_valid[j] && !out_ready[j];
  end
  // An empty channel replays the last word the processor consumed from it
  always_comb begin
    io_in = NBW'(RST_WORD);
    if (in_sel) io_in = empty[addr_in] ? hold[addr_in] : head[addr_in];
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      for (int i = 0; i < NUIOIN; i++) hold[i] <= NBW'(RST_WORD);
    end else begin
      for (int i = 0; i < NUIOIN; i++) if (pop[i]) hold[i] <= head[i];
    end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      out_data <= '0;
      out_valid <= '0;
    end else begin
      for (int i = 0; i < NUIOOU; i++)
        if (wr[i]) begin
          out_data[i*NBW +: NBW] <= io_out;
          out_valid[i] <= 1'b1;
        end else if (out_ready[i]) out_valid[i] <= 1'b0;
    end
`ifdef IO_STATUS_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      in_udf <= '0;
      ou_ovf <= '0;
    end else begin
      in_udf <= (stat_clr ? '0 : in_udf) | udf_ev;
      ou_ovf <= (stat_clr ? '0 : ou_ovf) | ovf_ev;
    end
`else
  logic unused_stat;
  assign unused_stat = ^{stat_clr, udf_ev, ovf_ev};
  assign in_udf = '0;
  assign ou_ovf = '0;
`endif
endmodule

// File: tb/tb_proc_io_fl.sv
// tb_proc_io_fl: directed scenarios plus random traffic checked against a queue-based reference model
module tb_proc_io_fl;
  localparam int NI = 6, NO = 6, FD = 4, W = 23;
`ifdef IO_STATUS_EN
  localparam bit STAT = 1'b1;
`else
  localparam bit STAT = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b0;
  logic [2:0] addr_in, addr_out;
  logic req_in, out_en, stat_clr;
  logic [W-1:0] io_in, io_out;
  logic [NI*W-1:0] in_data;
  logic [NI-1:0] in_valid, in_ready, in_udf;
  logic [NO*W-1:0] out_data;
  logic [NO-1:0] out_valid, out_ready, ou_ovf;
  int n_chk = 0, n_fail = 0;
  logic [W-1:0] q [NI][$];
  logic [W-1:0] hold [NI];
  logic [W-1:0] mod [NO];
  logic [NI-1:0] mudf;
  logic [NO-1:0] mov, movf;

  always #5 clk = ~clk;

  proc_io_fl #(.NBMANT(16), .NBEXPO(6), .NUIOIN(NI), .NUIOOU(NO), .FDEPTH(FD)) dut (
    .clk(clk), .rst(rst), .addr_in(addr_in), .req_in(req_in), .io_in(io_in),
    .addr_out(addr_out), .out_en(out_en), .io_out(io_out), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .in_udf(in_udf), .ou_ovf(ou_ovf), .stat_clr(stat_clr)
  );

  task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    addr_in = '0; req_in = 0; addr_out = '0; out_en = 0; io_out = '0;
    in_data = '0; in_valid = '0; out_ready = '0; stat_clr = 0;
  endtask

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin q[k].delete(); hold[k] = '0; end
    for (int j = 0; j < NO; j++) mod[j] = '0;
    mudf = '0; movf = '0; mov = '0;
  endtask

  task automatic chk_regs();
    logic [NO*W-1:0] od;
    for (int j = 0; j < NO; j++) od[j*W +: W] = mod[j];
    chk("out_valid", out_valid, mov);
    chk("out_data", out_data, od);
    chk("in_udf", in_udf, STAT ? mudf : '0);
    chk("ou_ovf", ou_ovf, STAT ? movf : '0);
  endtask

  // inputs are driven just after a falling edge; one call covers one rising edge
  task automatic cyc();
    int sz [NI];
    logic [W-1:0] exp_io;
    logic [NI-1:0] rdy;
    #1;
    exp_io = '0;
    if (addr_in < NI) exp_io = q[addr_in].size() > 0 ? q[addr_in][0] : hold[addr_in];
    chk("io_in", io_in, exp_io);
    for (int k = 0; k < NI; k++) rdy[k] = q[k].size() < FD;
    chk("in_ready", in_ready, rdy);
    for (int k = 0; k < NI; k++) sz[k] = q[k].size();
    if (stat_clr) begin mudf = '0; movf = '0; end
    if (req_in && addr_in < NI) begin
      if (sz[addr_in] > 0) hold[addr_in] = q[addr_in].pop_front();
      else mudf[addr_in] = 1'b1;
    end
    for (int k = 0; k < NI; k++)
      if (in_valid[k] && sz[k] < FD) q[k].push_back(in_data[k*W +: W]);
    for (int j = 0; j < NO; j++)
      if (out_en && addr_out == j) begin
        if (mov[j] && !out_ready[j]) movf[j] = 1'b1;
        mod[j] = io_out;
        mov[j] = 1'b1;
      end else if (out_ready[j]) mov[j] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_regs();
  endtask

  task automatic push1(input int k, input logic [W-1:0] v);
    idle(); in_valid[k] = 1'b1; in_data[k*W +: W] = v; cyc();
  endtask

  task automatic pop1(input int k);
    idle(); addr_in = 3'(k); req_in = 1'b1; cyc();
  endtask

  initial begin
    idle();
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, {NI{1'b1}});
    chk_regs();
    rst = 1'b1;
    // 1: asynchronous reset with data in flight
    for (int i = 1; i <= 3; i++) push1(2, W'(i + 40));
    idle(); out_en = 1; addr_out = 3'd0; io_out = 23'h55; cyc();
    idle(); addr_in = 3'd2;
    #2 rst = 1'b0;
    #1;
    model_reset();
    chk("async_in_ready", in_ready, {NI{1'b1}});
    chk("async_out_valid", out_valid, '0);
    chk("async_io_in", io_in, '0);
    @(negedge clk);
    rst = 1'b1;
    // 2: fill to full, refused push, then drain across pointer wrap
    for (int i = 1; i <= 4; i++) push1(0, W'(i));
    #1 chk("full_ready0", in_ready[0], 1'b0);
    @(negedge clk);
    push1(0, 23'd99);
    for (int i = 1; i <= 2; i++) begin
      idle(); #1 chk("wrap_seq", io_in, W'(i)); @(negedge clk); pop1(0);
    end
    push1(0, 23'd5);
    push1(0, 23'd6);
    for (int i = 3; i <= 6; i++) begin
      idle(); #1 chk("wrap_seq", io_in, W'(i)); @(negedge clk); pop1(0);
    end
    // 3: underflow replays the held word
    push1(1, 23'h1234);
    pop1(1);
    pop1(1);
    idle(); addr_in = 3'd1;
    #1 chk("udf_hold", io_in, 23'h1234);
    chk("udf_flag", in_udf[1], STAT);
    @(negedge clk);
    idle(); stat_clr = 1'b1; cyc();
    chk("udf_clr", in_udf, '0);
    // 4: simultaneous push and pop at occupancy 2
    push1(3, 23'h31);
    push1(3, 23'h32);
    idle(); addr_in = 3'd3; req_in = 1'b1; in_valid[3] = 1'b1; in_data[3*W +: W] = 23'h33; cyc();
    pop1(3);
    pop1(3);
    pop1(3);
    idle(); addr_in = 3'd3;
    #1 chk("sim_last", io_in, 23'h33);
    @(negedge clk);
    // 5: output overwrite and handshake
    idle(); out_en = 1; addr_out = 3'd5; io_out = 23'hABC; cyc();
    chk("ou_valid5", out_valid[5], 1'b1);
    idle(); out_en = 1; addr_out = 3'd5; io_out = 23'hDEF; cyc();
    chk("ou_data5", out_data[5*W +: W], 23'hDEF);
    chk("ou_ovf5", ou_ovf[5], STAT);
    idle(); out_ready[5] = 1'b1; cyc();
    chk("ou_drain5", out_valid[5], 1'b0);
    // 6: out-of-range addresses
    push1(4, 23'h44);
    idle(); addr_in = 3'd7; req_in = 1'b1; addr_out = 3'd7; out_en = 1; io_out = 23'h7;
    #1 chk("oor_io_in", io_in, '0);
    @(negedge clk);
    idle(); addr_in = 3'd7; req_in = 1'b1; addr_out = 3'd6; out_en = 1; io_out = 23'h7; cyc();
    pop1(4);
    // random traffic
    for (int n = 0; n < 1500; n++) begin
      addr_in = 3'($urandom_range(0, 7));
      req_in = $urandom_range(0, 2) == 0;
      addr_out = 3'($urandom_range(0, 7));
      out_en = $urandom_range(0, 2) == 0;
      io_out = W'($urandom);
      for (int k = 0; k < NI; k++) in_data[k*W +: W] = W'($urandom);
      in_valid = NI'($urandom) & NI'($urandom);
      out_ready = NO'($urandom);
      stat_clr = $urandom_range(0, 15) == 0;
      cyc();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/proc_io_fl.md
Name: proc_io_fl

Overview:
- Parametrised I/O subsystem for the floating-point processor (core_fl / proc_fl family).
- Replaces the bare io_in/addr_in/req_in and io_out/addr_out/out_en wiring.
- Input side: NUIOIN buffered input channels, each a per-channel first-word-fall-through FIFO with valid/ready handshake.
- Output side: NUIOOU registered output channels, each with valid/ready handshake.
- Sits between the processor I/O pins and external peripherals.

Parameters:
- NBMANT, 16, mantissa bits.
- NBEXPO, 6, exponent bits. Word width is NBW = NBMANT+NBEXPO+1.
- NUIOIN, 8, number of input channels (>=1).
- NUIOOU, 8, number of output channels (>=1).
- FDEPTH, 4, entries per input FIFO; power of 2, >=2.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset; asynchronous, active-low.
- addr_in  in  $clog2(NUIOIN)  processor input channel select.
- req_in  in  1  processor read strobe; pops the selected FIFO.
- io_in  out  NBW  data to processor for channel addr_in.
- addr_out  in  $clog2(NUIOOU)  processor output channel select.
- out_en  in  1  processor write strobe.
- io_out  in  NBW  data from processor.
- in_data  in  NUIOIN*NBW  peripheral input words; channel k occupies bits [k*NBW +: NBW].
- in_valid  in  NUIOIN  per-channel input valid.
- in_ready  out  NUIOIN  per-channel input ready (FIFO not full).
- out_data  out  NUIOOU*NBW  per-channel output registers.
- out_valid  out  NUIOOU  per-channel output valid.
- out_ready  in  NUIOOU  per-channel peripheral accept.
- in_udf  out  NUIOIN  sticky underflow flags.
- ou_ovf  out  NUIOOU  sticky overflow flags.
- stat_clr  in  1  clears all sticky flags.

Behaviour:
Reset (rst=0, asynchronous):
- All FIFOs empty.
- in_ready all 1.
- Channel hold registers, out_data, out_valid, in_udf and ou_ovf all 0.

Input FIFO k:
- Push when in_valid[k] & in_ready[k].
- in_ready[k] = !full[k], combinational from pointers.
- Pointers are $clog2(FDEPTH)+1 bits wide; full/empty are derived from the MSB comparison. Wrap-around is natural modulo 2*FDEPTH.

io_in:
- Combinational.
- If FIFO[addr_in] is non-empty: its head word (zero-latency fall-through).
- Otherwise: hold[addr_in], the last word popped from that channel.

Pop:
- On a clock edge with req_in=1 and FIFO[addr_in] non-empty: pop it and load hold[addr_in] with the popped word.
- If req_in=1 and FIFO[addr_in] is empty: no pop, hold unchanged, in_udf[addr_in] set.

Simultaneous push and pop on the same channel:
- Both take effect; occupancy is unchanged.
- When full, a pop and push in the same cycle is allowed only if in_ready was already 1. in_ready does not look ahead at the pop, so a full FIFO refuses the push that cycle.
- When empty, a same-cycle push is not visible to io_in until the next cycle; the pop is treated as underflow.

Output channel j:
- On out_en=1 with addr_out=j: out_data[j] <= io_out and out_valid[j] <= 1.
- If out_valid[j] & !out_ready[j] at that edge, the old word is overwritten and ou_ovf[j] is set.
- Handshake: out_valid[j] & out_ready[j] at an edge clears out_valid[j], unless out_en writes channel j on the same edge, in which case valid stays 1 with the new data and no overflow is raised.

Address range:
- addr_in >= NUIOIN: io_in = 0, no pop, no flag.
- addr_out >= NUIOOU: the write is ignored.

Status:
- stat_clr=1 clears all flags.
- If a flag event coincides with stat_clr, the set wins.

Latency:
- Peripheral push to io_in visibility: 1 cycle.
- Processor write to out_valid: 1 cycle.

Optional Feature:
IO_STATUS_EN
- Defined: in_udf, ou_ovf and stat_clr behave as above.
- Undefined: flag registers are not built; in_udf and ou_ovf are tied to 0 and stat_clr is ignored.
- All data-path behaviour is identical in both cases.

Decomposition:
- Package proc_io_fl_pkg holds:
  - function nbw(NBMANT, NBEXPO);
  - function ptrw(FDEPTH) = $clog2(FDEPTH)+1;
  - localparams for the reset word (0).
- One sub-module, fifo_fl: a single-clock FWFT FIFO, parameters NBDATA and FDEPTH, ports clk, rst, push, din, pop, dout, full, empty. It is instantiated NUIOIN times in a generate loop.
- Output registers and the read mux stay in proc_io_fl.

Test Plan:
1. Reset mid-operation: fill ch2 with 3 words, assert rst=0 asynchronously between edges -> in_ready all 1, out_valid 0, io_in (addr_in=2) = 0 immediately.
2. Fill and wrap: with FDEPTH=4, push ch0 words 1..4 -> in_ready[0]=0, and a 5th push is refused. Pop 2, push 5 and 6, pop 4 -> io_in sequence is 1,2,3,4,5,6, showing correct order across pointer wrap.
3. Underflow hold: pop ch1 once (word 0x1234), then req_in on empty ch1 -> io_in stays 0x1234 and in_udf[1]=1. stat_clr -> in_udf=0.
4. Simultaneous push/pop on ch3 at occupancy 2 -> occupancy stays 2 and data order is preserved.
5. Output handshake: out_en ch5 with 0xABC and out_ready[5]=0 -> out_valid[5]=1 next cycle. Write 0xDEF -> out_data=0xDEF and ou_ovf[5]=1. Raise out_ready -> out_valid clears the next cycle.
6. Out-of-range: with NUIOIN=6, addr_in=7 plus req_in -> io_in=0, no FIFO changes, no flags. Rebuild without IO_STATUS_EN and rerun scenario 3 -> in_udf stays 0 while data behaviour is unchanged.
